// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector, Mealy or Moore output by parameter.
// Optional saturating match counter enabled by defining SEQ_DETECT_CNT_EN.
module seq_detect_param #(
   parameter int unsigned      PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
   parameter bit               MOORE    = 1'b0,
   parameter int unsigned      CNT_W    = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in,
   input  logic                       in_valid,
   input  logic                       cfg_load,
   input  logic [PAT_W-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
   input  logic                       cfg_overlap,
   output logic                       out,
   output logic [CNT_W-1:0]           match_cnt,
   input  logic                       cnt_clr
);

   localparam int unsigned      LEN_W   = $clog2(PAT_W + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ovl_q, ovl_d;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic             out_q, out_d;

   logic [PAT_W-1:0] cand;
   logic [PAT_W-1:0] mask;
   logic [LEN_W:0]   fill_p1;
   logic             match;

   assign cand    = {hist_q[PAT_W-2:0], in};
   assign fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         if (i < 32'(len_q)) mask[i] = 1'b1;
      end
   end

   // cfg_load suppresses any match on the same cycle.
   assign match = in_valid && !cfg_load && (fill_p1 >= {1'b0, len_q})
                  && (((cand ^ pat_q) & mask) == '0);

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      out_d  = match;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         len_d  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
         ovl_d  = cfg_overlap;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = cand;
         if (match && !ovl_q)       fill_d = '0;
         else if (fill_q != LEN_MAX) fill_d = fill_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pat_q  <= PAT_INIT;
         len_q  <= LEN_MAX;
         ovl_q  <= 1'b1;
         hist_q <= '0;
         fill_q <= '0;
         out_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         out_q  <= out_d;
      end
   end

   assign out = MOORE ? out_q : (rstn & match);

`ifdef SEQ_DETECT_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)                  cnt_d = '0;
      else if (match && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign match_cnt = cnt_q;

   logic unused_sig;
   assign unused_sig = hist_q[PAT_W-1];
`else
   assign match_cnt = '0;

   logic unused_sig;
   assign unused_sig = ^{cnt_clr, hist_q[PAT_W-1]};
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: Mealy and Moore instances driven in lockstep.
module tb_seq_detect_param;

   localparam int unsigned PAT_W = 4;
   localparam int unsigned LEN_W = $clog2(PAT_W + 1);
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             in = 1'b0;
   logic             in_valid = 1'b0;
   logic             cfg_load = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = 4'b1011;
   logic [LEN_W-1:0] cfg_len = 3'd4;
   logic             cfg_overlap = 1'b1;
   logic             cnt_clr = 1'b0;
   logic             out_mealy, out_moore;
   logic [CNT_W-1:0] cnt_mealy, cnt_moore;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic        moore_q[$];
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   seq_detect_param #(.PAT_W(PAT_W), .PAT_INIT(4'b1011), .MOORE(1'b0), .CNT_W(CNT_W)) u_mealy (
      .clk(clk), .rstn(rstn), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .out(out_mealy), .match_cnt(cnt_mealy), .cnt_clr(cnt_clr));

   seq_detect_param #(.PAT_W(PAT_W), .PAT_INIT(4'b1011), .MOORE(1'b1), .CNT_W(CNT_W)) u_moore (
      .clk(clk), .rstn(rstn), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .out(out_moore), .match_cnt(cnt_moore), .cnt_clr(cnt_clr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus; exp is the match condition the spec predicts for this cycle.
   task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                       input logic exp, input string tag);
      logic mq;
      @(negedge clk);
      in_valid = v;
      in       = b;
      cfg_load = ld;
      cnt_clr  = clr;
      #1;
      check({tag, " mealy"}, 32'(out_mealy), 32'(exp));
      moore_q.push_back(exp);
`ifdef SEQ_DETECT_CNT_EN
      if (clr)                      exp_cnt = 0;
      else if (exp && exp_cnt < 3)  exp_cnt = exp_cnt + 1;
`endif
      @(posedge clk);
      #1;
      mq = moore_q.pop_front();
      check({tag, " moore"}, 32'(out_moore), 32'(mq));
      check({tag, " cnt"}, 32'(cnt_mealy), exp_cnt);
      check({tag, " cnt_moore"}, 32'(cnt_moore), exp_cnt);
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "load");
   endtask

   task automatic stream(input logic [15:0] bits, input logic [15:0] exps,
                         input int unsigned n, input string tag);
      for (int unsigned i = 0; i < n; i++)
         step(1'b1, bits[n-1-i], 1'b0, 1'b0, exps[n-1-i], tag);
   endtask

   initial begin
      #2;
      check("rst mealy", 32'(out_mealy), 0);
      check("rst moore", 32'(out_moore), 0);
      check("rst cnt", 32'(cnt_mealy), 0);
      @(negedge clk);
      rstn = 1'b1;

      // default 1011, overlapping
      stream(16'b1011011, 16'b0001001, 7, "dflt");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

      // non-overlapping
      load(4'b1011, 3'd4, 1'b0);
      stream(16'b1011011, 16'b0001000, 7, "novl");
      stream(16'b1011, 16'b0001, 4, "novl2");

      // len 3, pattern 010, overlapping; then same with a 2-cycle gap
      load(4'b1010, 3'd3, 1'b1);
      stream(16'b01010, 16'b00101, 5, "len3");
      load(4'b1010, 3'd3, 1'b1);
      stream(16'b010, 16'b001, 3, "gap_a");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_idle");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_idle");
      stream(16'b10, 16'b01, 2, "gap_b");

      // cfg_load colliding with the final bit
      load(4'b1011, 3'd4, 1'b1);
      stream(16'b101, 16'b000, 3, "coll_pre");
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "coll_ld");
      stream(16'b1011, 16'b0001, 4, "coll_post");

      // length clamping: 0 and 7 both mean PAT_W
      load(4'b0011, 3'd0, 1'b1);
      stream(16'b0011, 16'b0001, 4, "clamp0");
      load(4'b0110, 3'd7, 1'b1);
      stream(16'b110110, 16'b000001, 6, "clamp7");

      // asynchronous reset mid-cycle
      load(4'b1011, 3'd4, 1'b1);
      stream(16'b101, 16'b000, 3, "arst_pre");
      @(negedge clk);
      in_valid = 1'b1;
      in       = 1'b1;
      #1;
      check("arst pre mealy", 32'(out_mealy), 1);
      #1;
      rstn = 1'b0;
      #1;
      check("arst mealy", 32'(out_mealy), 0);
      check("arst moore", 32'(out_moore), 0);
      check("arst cnt", 32'(cnt_mealy), 0);
      in_valid = 1'b0;
      moore_q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rstn = 1'b1;
      stream(16'b11011, 16'b00001, 5, "arst_post");

      // counter saturation and clear priority
      load(4'b0001, 3'd1, 1'b1);
      stream(16'b111111, 16'b111111, 6, "cnt");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "cnt_clr");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "cnt_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised, runtime-programmable serial bit-pattern detector. It succeeds the fixed-pattern Mealy, Moore and gate-level detector FSMs.
- Pattern, length and overlap mode are loaded at runtime. Output style (Mealy or Moore) is selected by parameter.
- Sits on a 1-bit serial input stream qualified by a valid strobe. Flags each pattern occurrence to downstream control logic.

Parameters:
- PAT_W, 4, maximum pattern length in bits (2..16).
- PAT_INIT, 4'b1011 (PAT_W bits), pattern loaded at reset.
- MOORE, 0, 0 = Mealy output (combinational from current input), 1 = Moore output (registered, one cycle later).
- CNT_W, 8, width of the match counter (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- in  input  1  serial data bit
- in_valid  input  1  in is sampled this cycle when high
- cfg_load  input  1  load cfg_* fields this cycle
- cfg_pattern  input  PAT_W  pattern; cfg_pattern[cfg_len-1] is the first bit received, [0] the last
- cfg_len  input  $clog2(PAT_W+1)  active pattern length, 1..PAT_W
- cfg_overlap  input  1  1 = overlapping matches allowed
- out  output  1  match indication
- match_cnt  output  CNT_W  saturating match count (present only with the optional feature; tie to 0 otherwise)
- cnt_clr  input  1  synchronous clear of match_cnt (ignored without the optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn. All state clears on rstn low, independent of clk.
- Reset values:
  - pattern register = PAT_INIT
  - length register = PAT_W
  - overlap register = 1
  - history shift register = 0
  - fill counter = 0
  - Moore out register = 0
  - match_cnt = 0
  - out = 0 (with rstn low, Mealy out is forced to 0)
- History and fill:
  - On in_valid, hist <= {hist[PAT_W-2:0], in}.
  - fill counter increments, saturating at PAT_W.
- Match condition (evaluated on the candidate history {hist[PAT_W-2:0], in}):
  - in_valid = 1
  - (fill + 1) >= len
  - the low len bits of the candidate history equal the low len bits of the pattern register
- Mealy (MOORE=0): out = match condition, combinationally, in the same cycle the final bit is presented. 0 whenever in_valid is 0.
- Moore (MOORE=1): out_reg <= match condition each clk. out is high for exactly one cycle, the cycle after the final bit.
- Overlap mode:
  - overlap=1: history and fill are unaffected by a match.
  - overlap=0: on a match, fill <= 0, so the next match needs len fresh bits. hist is still updated.
- Configuration:
  - cfg_load=1 latches cfg_pattern, cfg_len and cfg_overlap, and clears hist and fill.
  - cfg_len of 0 or greater than PAT_W is clamped to PAT_W.
- cfg_load together with in_valid: cfg_load wins. The in bit is discarded, no match is generated, and the Moore out_reg is loaded 0.
- A Moore out pulse already registered before a cfg_load is still presented in the following cycle.
- in_valid low: hist, fill and the counter hold. In Moore mode out_reg <= 0.
- Reset mid-stream: partial history is lost; detection restarts from an empty history with PAT_INIT.
- No-gap streams: back-to-back matches in overlap mode produce consecutive out pulses, e.g. len=2, pattern 11, input 1,1,1 -> out on bits 2 and 3.

Optional Feature:
- Macro: SEQ_DETECT_CNT_EN.
- Defined:
  - match_cnt increments by 1 on every match condition and saturates at all-ones.
  - cnt_clr=1 sets match_cnt to 0. It takes priority over a simultaneous increment.
  - cfg_load does not clear the counter.
- Undefined: no counter flops; match_cnt is driven constant 0 and cnt_clr is unused.

Test Plan:
- Reset, then default config (1011, overlap), stream 1,0,1,1,0,1,1 with in_valid=1 -> MOORE=0: out high on bits 4 and 7. MOORE=1: out high one cycle after each of those bits. Exactly 2 pulses.
- cfg_load pattern 1011, len 4, overlap=0; same stream -> out only on bit 4. Bit 7 gives no match (fill 3 < 4). Continue with 1,0,1,1 -> match on the final 1.
- cfg_load len 3, pattern 3'b010 (upper bits X), overlap=1; stream 0,1,0,1,0 -> matches on bits 3 and 5. Check that in_valid gaps of 2 cycles inserted between bits 3 and 4 give the same result.
- Assert cfg_load in the same cycle as the 4th bit of 1011 -> no pulse. Then stream 1,0,1,1 -> a pulse on the 4th new bit only.
- Drop rstn asynchronously (mid-cycle) after 1,0,1 -> out=0 immediately. After release, stream 1 -> no match. Then 1,0,1,1 -> match.
- With SEQ_DETECT_CNT_EN, CNT_W=2, pattern len 1, pattern 1, stream of six 1s -> match_cnt 1,2,3,3,3,3. Pulse cnt_clr together with a matching bit -> match_cnt = 0.
